// File: rtl/wb_slave_decoder.sv
// wb_slave_decoder: single-master to four-slave Wishbone decoder.
// Each request is decoded in IDLE, then the selected slave is strobed in BUSY.
// BUSY is guarded by a per-transfer timeout. Timeouts and unmapped addresses
// produce a one-cycle bus error in ERR. The first fault is held for readout.
module wb_slave_decoder #(
   parameter logic [31:0] S0_BASE    = 32'h0000_0000,
   parameter logic [31:0] S1_BASE    = 32'h1000_0000,
   parameter logic [31:0] S2_BASE    = 32'h8000_0000,
   parameter logic [31:0] S3_BASE    = 32'h9000_0000,
   parameter logic [31:0] SN_MASK    = 32'hF000_0000,
   parameter logic [7:0]  TMO_CYCLES = 8'd255
) (
   input  logic         i_clk,
   input  logic         i_rb,
   input  logic         i_m_cyc,
   input  logic         i_m_stb,
   input  logic         i_m_we,
   input  logic [3:0]   i_m_sel,
   input  logic [31:0]  i_m_adr,
   input  logic [31:0]  i_m_dat,
   output logic [31:0]  o_m_dat,
   output logic         o_m_ack,
   output logic         o_m_err,
   output logic [3:0]   o_s_cyc,
   output logic [3:0]   o_s_stb,
   output logic         o_s_we,
   output logic [3:0]   o_s_sel,
   output logic [31:0]  o_s_adr,
   output logic [31:0]  o_s_dat,
   input  logic [127:0] i_s_dat,
   input  logic [3:0]   i_s_ack,
   input  logic         i_fault_clr,
   output logic         o_fault_valid,
   output logic [1:0]   o_fault_code,
   output logic [31:0]  o_fault_adr
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ERR  = 2'd2
   } state_e;

   localparam logic [1:0] CODE_UNMAPPED = 2'b01;
   localparam logic [1:0] CODE_TIMEOUT  = 2'b10;

   state_e      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        fault_valid_q, fault_valid_d;
   logic [1:0]  fault_code_q, fault_code_d;
   logic [31:0] fault_adr_q, fault_adr_d;

   logic        req;
   logic [3:0]  hit;
   logic        any_hit;
   logic [1:0]  hit_idx;
   logic        sel_ack;
   logic        err_enter;
   logic [1:0]  err_code;

   assign req     = i_m_cyc & i_m_stb;
   assign any_hit = |hit;
   assign sel_ack = i_s_ack[idx_q] & i_m_stb;

   // Address decode against each slave window, lowest index wins on overlap.
   always_comb begin
      hit[0] = (i_m_adr & SN_MASK) == S0_BASE;
      hit[1] = (i_m_adr & SN_MASK) == S1_BASE;
      hit[2] = (i_m_adr & SN_MASK) == S2_BASE;
      hit[3] = (i_m_adr & SN_MASK) == S3_BASE;
      if (hit[0])      hit_idx = 2'd0;
      else if (hit[1]) hit_idx = 2'd1;
      else if (hit[2]) hit_idx = 2'd2;
      else             hit_idx = 2'd3;
   end

   // Next-state logic and master/slave handshake outputs.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      err_enter = 1'b0;
      err_code  = 2'b00;
      o_m_ack   = 1'b0;
      o_m_err   = 1'b0;
      o_m_dat   = 32'h0;
      o_s_stb   = 4'b0000;
      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (any_hit) begin
                  idx_d   = hit_idx;
                  cnt_d   = 8'd0;
                  state_d = ST_BUSY;
               end else begin
                  err_enter = 1'b1;
                  err_code  = CODE_UNMAPPED;
                  state_d   = ST_ERR;
               end
            end
         end
         ST_BUSY: begin
            o_s_stb[idx_q] = i_m_stb;
            o_m_ack        = sel_ack;
            o_m_dat        = i_s_dat[{idx_q, 5'd0} +: 32];
            if (!req || sel_ack) begin
               // Abort or completion: an ack on the threshold cycle still wins.
               state_d = ST_IDLE;
            end else if (cnt_q == TMO_CYCLES - 8'd1) begin
               err_enter = 1'b1;
               err_code  = CODE_TIMEOUT;
               state_d   = ST_ERR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_ERR: begin
            o_m_err = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Fault capture: first fault sticks; a clear coinciding with a fault keeps the new one.
   always_comb begin
      fault_valid_d = fault_valid_q;
      fault_code_d  = fault_code_q;
      fault_adr_d   = fault_adr_q;
      if (err_enter && (!fault_valid_q || i_fault_clr)) begin
         fault_valid_d = 1'b1;
         fault_code_d  = err_code;
         fault_adr_d   = i_m_adr;
      end else if (i_fault_clr) begin
         fault_valid_d = 1'b0;
         fault_code_d  = 2'b00;
         fault_adr_d   = 32'h0;
      end
   end

   // State, slave index, timeout counter and fault capture registers.
   always_ff @(posedge i_clk or negedge i_rb) begin
      if (!i_rb) begin
         state_q       <= ST_IDLE;
         idx_q         <= 2'd0;
         cnt_q         <= 8'd0;
         fault_valid_q <= 1'b0;
         fault_code_q  <= 2'b00;
         fault_adr_q   <= 32'h0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         fault_valid_q <= fault_valid_d;
         fault_code_q  <= fault_code_d;
         fault_adr_q   <= fault_adr_d;
      end
   end

   assign o_s_cyc       = o_s_stb;
   assign o_s_we        = i_m_we;
   assign o_s_sel       = i_m_sel;
   assign o_s_adr       = i_m_adr;
   assign o_s_dat       = i_m_dat;
   assign o_fault_valid = fault_valid_q;
   assign o_fault_code  = fault_code_q;
   assign o_fault_adr   = fault_adr_q;

endmodule

// File: tb/tb_wb_slave_decoder.sv
// Testbench for wb_slave_decoder: directed transfers checked every cycle against
// a transaction-level model, plus literal expectations for each scenario.
module tb_wb_slave_decoder;

   localparam int TMO = 255;

   logic         clk = 1'b0;
   logic         rb  = 1'b1;
   logic         m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
   logic [3:0]   m_sel = 4'h0;
   logic [31:0]  m_adr = 32'h0, m_dat = 32'h0;
   logic [31:0]  o_m_dat;
   logic         o_m_ack, o_m_err;
   logic [3:0]   o_s_cyc, o_s_stb;
   logic         o_s_we;
   logic [3:0]   o_s_sel;
   logic [31:0]  o_s_adr, o_s_dat;
   logic [127:0] s_dat = {32'h9999_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0B00_7000};
   logic [3:0]   s_ack = 4'h0;
   logic         fclr = 1'b0;
   logic         o_fault_valid;
   logic [1:0]   o_fault_code;
   logic [31:0]  o_fault_adr;

   int checks = 0;
   int errors = 0;

   wb_slave_decoder dut (
      .i_clk(clk), .i_rb(rb),
      .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we), .i_m_sel(m_sel),
      .i_m_adr(m_adr), .i_m_dat(m_dat),
      .o_m_dat(o_m_dat), .o_m_ack(o_m_ack), .o_m_err(o_m_err),
      .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we), .o_s_sel(o_s_sel),
      .o_s_adr(o_s_adr), .o_s_dat(o_s_dat),
      .i_s_dat(s_dat), .i_s_ack(s_ack),
      .i_fault_clr(fclr),
      .o_fault_valid(o_fault_valid), .o_fault_code(o_fault_code), .o_fault_adr(o_fault_adr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   bit          md_active = 0;   // a slave is currently engaged
   int          md_tgt    = 0;   // engaged slave
   int          md_age    = 0;   // engaged cycles already spent without ack
   bit          md_err    = 0;   // this cycle is the error response
   bit          md_fv     = 0;
   logic [1:0]  md_fc     = 2'b00;
   logic [31:0] md_fa     = 32'h0;

   function automatic int slave_of(input logic [31:0] adr);
      case (adr[31:28])
         4'h0:    return 0;
         4'h1:    return 1;
         4'h8:    return 2;
         4'h9:    return 3;
         default: return -1;
      endcase
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rb);
         if (!rb) begin
            md_active = 0; md_tgt = 0; md_age = 0; md_err = 0;
            md_fv = 0; md_fc = 2'b00; md_fa = 32'h0;
         end else begin
            bit         req;
            bit         fault;
            logic [1:0] fcode;
            int         t;
            req   = m_cyc && m_stb;
            fault = 0;
            fcode = 2'b00;
            if (md_err) begin
               md_err = 0;
            end else if (md_active) begin
               if (!req || s_ack[md_tgt]) begin
                  md_active = 0;
               end else begin
                  md_age = md_age + 1;
                  if (md_age == TMO) begin
                     md_active = 0; md_err = 1; fault = 1; fcode = 2'b10;
                  end
               end
            end else if (req) begin
               t = slave_of(m_adr);
               if (t < 0) begin
                  md_err = 1; fault = 1; fcode = 2'b01;
               end else begin
                  md_active = 1; md_tgt = t; md_age = 0;
               end
            end
            if (fault && (!md_fv || fclr)) begin
               md_fv = 1; md_fc = fcode; md_fa = m_adr;
            end else if (fclr) begin
               md_fv = 0; md_fc = 2'b00; md_fa = 32'h0;
            end
         end
      end
   end

   // Every-cycle comparison of all DUT outputs against the model.
   initial begin
      forever begin
         logic [3:0]  e_stb;
         logic        e_ack;
         logic [31:0] e_dat;
         @(negedge clk);
         e_stb = md_active ? (4'(m_stb) << md_tgt) : 4'h0;
         e_ack = md_active && m_stb && s_ack[md_tgt];
         e_dat = md_active ? s_dat[md_tgt*32 +: 32] : 32'h0;
         check("m_stb_out", 32'(o_s_stb), 32'(e_stb));
         check("m_cyc_out", 32'(o_s_cyc), 32'(e_stb));
         check("m_ack", 32'(o_m_ack), 32'(e_ack));
         check("m_err", 32'(o_m_err), 32'(md_err));
         check("m_dat", o_m_dat, e_dat);
         check("s_pass", {27'(o_s_sel), o_s_we}, {27'(m_sel), m_we});
         check("s_adr", o_s_adr, m_adr);
         check("s_dat", o_s_dat, m_dat);
         check("f_valid", 32'(o_fault_valid), 32'(md_fv));
         check("f_code", 32'(o_fault_code), 32'(md_fc));
         check("f_adr", o_fault_adr, md_fa);
      end
   end

   // ---------------- directed stimulus ----------------
   int          ack_at, err_at;
   logic [31:0] rdat;
   logic [3:0]  stb_seen;
   logic        obs_we;
   logic [3:0]  obs_sel;
   logic [31:0] obs_sdat;

   // Called just after a rising edge. Cycle 0 is the IDLE cycle that first
   // presents the request. ack_slv < 0 means no slave ever acks.
   task automatic run_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] wdat, input int ack_slv, input int ack_cyc,
                           input logic [3:0] noise, input int drop_cyc, input int clr_cyc,
                           input int max_cyc);
      ack_at = -1; err_at = -1; rdat = 32'h0; stb_seen = 4'h0;
      obs_we = 1'b0; obs_sel = 4'h0; obs_sdat = 32'h0;
      m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_sel = sel; m_adr = adr; m_dat = wdat;
      for (int n = 0; n < max_cyc; n++) begin
         if (ack_slv >= 0 && n == ack_cyc) s_ack = 4'b0001 << ack_slv;
         else if (n < ack_cyc)             s_ack = noise;
         else                              s_ack = 4'h0;
         fclr = (n == clr_cyc);
         if (n == drop_cyc) begin m_cyc = 1'b0; m_stb = 1'b0; end
         @(negedge clk);
         stb_seen = stb_seen | o_s_stb;
         if (o_m_ack && ack_at < 0) begin
            ack_at = n; rdat = o_m_dat; obs_we = o_s_we; obs_sel = o_s_sel; obs_sdat = o_s_dat;
         end
         if (o_m_err && err_at < 0) err_at = n;
         @(posedge clk); #1;
         if (ack_at >= 0 || err_at >= 0 || n == drop_cyc) break;
      end
      m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_sel = 4'h0; m_adr = 32'h0; m_dat = 32'h0;
      s_ack = 4'h0; fclr = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic pulse_clear();
      fclr = 1'b1;
      @(posedge clk); #1;
      fclr = 1'b0;
   endtask

   task automatic check_fault(input string tag, input logic v, input logic [1:0] c, input logic [31:0] a);
      check({tag, "_valid"}, 32'(o_fault_valid), 32'(v));
      check({tag, "_code"}, 32'(o_fault_code), 32'(c));
      check({tag, "_adr"}, o_fault_adr, a);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rb = 1'b0;
      @(negedge clk);
      check("rst_stb", 32'(o_s_stb), 32'h0);
      check("rst_ack_err", {30'h0, o_m_ack, o_m_err}, 32'h0);
      check("rst_dat", o_m_dat, 32'h0);
      check_fault("rst_fault", 1'b0, 2'b00, 32'h0);
      repeat (2) @(posedge clk);
      #1 rb = 1'b1;
      @(posedge clk); #1;

      // Read from slave 1: other slaves ack meanwhile and must be ignored.
      run_xfer(32'h1000_0010, 1'b0, 4'hF, 32'h0, 1, 3, 4'b1101, -1, -1, 20);
      check("rd_ack_at", ack_at, 3);
      check("rd_err_at", err_at, -1);
      check("rd_data", rdat, 32'hDEAD_BEEF);
      check("rd_stb_seen", 32'(stb_seen), 32'h2);

      // Write to slave 3.
      run_xfer(32'h9000_0004, 1'b1, 4'b0001, 32'h41, 3, 1, 4'h0, -1, -1, 20);
      check("wr_ack_at", ack_at, 1);
      check("wr_stb_seen", 32'(stb_seen), 32'h8);
      check("wr_we_sel", {27'(obs_sel), obs_we}, {27'h1, 1'b1});
      check("wr_dat", obs_sdat, 32'h41);

      // Unmapped access.
      run_xfer(32'h4000_0000, 1'b0, 4'hF, 32'h0, -1, 0, 4'h0, -1, -1, 20);
      check("um_err_at", err_at, 1);
      check("um_ack_at", ack_at, -1);
      check("um_stb_seen", 32'(stb_seen), 32'h0);
      check_fault("um_fault", 1'b1, 2'b01, 32'h4000_0000);
      pulse_clear();
      check_fault("clr1", 1'b0, 2'b00, 32'h0);

      // Slave 2 never acks: timeout after 255 BUSY cycles.
      run_xfer(32'h8000_0000, 1'b0, 4'hF, 32'h0, -1, 0, 4'h0, -1, -1, 300);
      check("to_err_at", err_at, TMO + 1);
      check("to_ack_at", ack_at, -1);
      check("to_stb_seen", 32'(stb_seen), 32'h4);
      check_fault("to_fault", 1'b1, 2'b10, 32'h8000_0000);

      // Second fault leaves the capture alone.
      run_xfer(32'h7000_0000, 1'b0, 4'hF, 32'h0, -1, 0, 4'h0, -1, -1, 20);
      check("um2_err_at", err_at, 1);
      check_fault("keep_fault", 1'b1, 2'b10, 32'h8000_0000);

      // Clear coinciding with a new fault: the new fault is captured.
      run_xfer(32'h5000_0000, 1'b0, 4'hF, 32'h0, -1, 0, 4'h0, -1, 0, 20);
      check_fault("clrnew_fault", 1'b1, 2'b01, 32'h5000_0000);
      pulse_clear();
      check_fault("clr2", 1'b0, 2'b00, 32'h0);

      // Slave 0 acks on the timeout threshold cycle: ack wins.
      run_xfer(32'h0000_0100, 1'b0, 4'hF, 32'h0, 0, TMO, 4'h0, -1, -1, 300);
      check("edge_ack_at", ack_at, TMO);
      check("edge_err_at", err_at, -1);
      check("edge_data", rdat, 32'h0B00_7000);
      check_fault("edge_fault", 1'b0, 2'b00, 32'h0);

      // Master abort on BUSY cycle 5.
      run_xfer(32'h0000_0200, 1'b0, 4'hF, 32'h0, -1, 0, 4'h0, 5, -1, 20);
      check("abort_ack_at", ack_at, -1);
      check("abort_err_at", err_at, -1);

      // Leave a fault captured, then reset in the middle of a transfer.
      run_xfer(32'h6000_0000, 1'b0, 4'hF, 32'h0, -1, 0, 4'h0, -1, -1, 20);
      check_fault("pre_rst", 1'b1, 2'b01, 32'h6000_0000);
      m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h1000_0000; m_sel = 4'hF;
      repeat (2) begin @(posedge clk); #1; end
      s_ack = 4'b0010;
      #1;
      check("pre_rst_ack", 32'(o_m_ack), 32'h1);
      #1 rb = 1'b0;
      #1;
      check("rst_mid_stb", 32'(o_s_stb), 32'h0);
      check("rst_mid_ack", 32'(o_m_ack), 32'h0);
      check_fault("rst_mid", 1'b0, 2'b00, 32'h0);
      @(posedge clk); #1;
      m_cyc = 1'b0; m_stb = 1'b0; m_adr = 32'h0; m_sel = 4'h0; s_ack = 4'h0;
      rb = 1'b1;
      @(posedge clk); #1;

      run_xfer(32'h1000_0020, 1'b0, 4'hF, 32'h0, 1, 2, 4'h0, -1, -1, 20);
      check("post_rst_ack_at", ack_at, 2);
      check("post_rst_data", rdat, 32'hDEAD_BEEF);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_slave_decoder.md
Name: wb_slave_decoder

Overview:
- Single-master to four-slave Wishbone decoder and bus controller, placed downstream of the MIPS core's instruction/data port arbiter.
- Decodes the master address to one slave and sequences the transfer with a one-cycle decode stage.
- Enforces a per-transfer timeout and returns a bus error on timeout or on an unmapped address.
- Captures the first fault address and type for software and debug readout.

Parameters:
S0_BASE, 32'h0000_0000, slave 0 base (boot ROM)
S1_BASE, 32'h1000_0000, slave 1 base (RAM)
S2_BASE, 32'h8000_0000, slave 2 base (GPIO)
S3_BASE, 32'h9000_0000, slave 3 base (UART)
SN_MASK, 32'hF000_0000, match mask applied to all slaves: hit when (adr & SN_MASK) == Sx_BASE
TMO_CYCLES, 8'd255, BUSY cycles without ack before a timeout error

Ports:
i_clk  in  1  clock
i_rb  in  1  reset, asynchronous, active-low
i_m_cyc  in  1  master cycle
i_m_stb  in  1  master strobe
i_m_we  in  1  master write enable
i_m_sel  in  4  master byte selects
i_m_adr  in  32  master address
i_m_dat  in  32  master write data
o_m_dat  out  32  read data to master
o_m_ack  out  1  transfer acknowledge to master
o_m_err  out  1  bus error to master, one-cycle pulse
o_s_cyc  out  4  per-slave cycle (equal to o_s_stb)
o_s_stb  out  4  per-slave strobe, one-hot or zero
o_s_we  out  1  shared write enable
o_s_sel  out  4  shared byte selects
o_s_adr  out  32  shared address
o_s_dat  out  32  shared write data
i_s_dat  in  128  slave read data, slave k at bits [32k+31:32k]
i_s_ack  in  4  slave acknowledges
i_fault_clr  in  1  clears fault capture
o_fault_valid  out  1  sticky fault flag
o_fault_code  out  2  01 = unmapped, 10 = timeout, 00 = none
o_fault_adr  out  32  address of the first captured fault

Behaviour:
- Request: valid when i_m_cyc & i_m_stb. The master holds the request and its attributes stable until ack or err.
- FSM states: IDLE, BUSY, ERR. Reset puts the FSM in IDLE.
- Reset values: every output is 0, the latched slave index is 0, and the timeout counter is 0.
- IDLE:
  - Request with a hit: latch the hit index, using the lowest index if more than one slave hits. Clear the counter and go to BUSY.
  - Request with no hit: go to ERR with cause unmapped.
  - No request: stay in IDLE. o_s_stb = 0 throughout IDLE.
- BUSY:
  - o_s_stb[idx] = i_m_stb; all other strobes are 0.
  - o_s_we, o_s_sel, o_s_adr and o_s_dat pass the master signals through combinationally in all states.
  - o_m_ack = i_s_ack[idx] & i_m_stb, combinational. o_m_dat = i_s_dat slice idx whenever BUSY, otherwise 0.
  - Ack: return to IDLE on the next edge.
  - Master drops stb or cyc (abort): return to IDLE with no ack and no error.
  - Otherwise increment the counter. When the counter equals TMO_CYCLES-1 and there is no ack, go to ERR with cause timeout.
  - Ack in the same cycle as the timeout threshold: the ack wins and no error is raised.
  - Acks from non-selected slaves are ignored.
- ERR:
  - Lasts exactly one cycle with o_m_err = 1, o_m_ack = 0 and o_s_stb = 0, then returns to IDLE.
- Latency: ack reaches the master no earlier than cycle 1 after the request. Minimum throughput is 2 cycles per transfer, because IDLE is visited between transfers.
- Fault capture:
  - On entering ERR while o_fault_valid = 0: set valid, load the code and the faulting i_m_adr.
  - Later faults while valid = 1 do not overwrite the capture.
  - i_fault_clr with no new fault: valid, code and adr all go to 0.
  - i_fault_clr in the same cycle as a new fault: the new fault is captured and valid stays 1.
- Asynchronous reset mid-transfer: all strobes drop immediately, the FSM returns to IDLE and the fault capture is cleared.

Test Plan:
- Read from 32'h1000_0010 where slave 1 acks after 3 cycles with 32'hDEADBEEF -> o_s_stb = 4'b0010 from cycle 1; o_m_ack high for one cycle with o_m_dat = 32'hDEADBEEF; no other strobe ever set.
- Write to 32'h9000_0004 with sel 4'b0001 and data 32'h41 -> slave 3 sees we = 1, sel = 4'b0001, dat = 32'h41; ack propagates; the FSM returns to IDLE.
- Access to 32'h4000_0000 -> o_m_err pulses exactly 1 cycle at cycle 1; fault_valid = 1, code = 01, adr = 32'h4000_0000; no slave strobe.
- Slave 2 never acks -> o_m_err pulses after TMO_CYCLES = 255 BUSY cycles; code = 10. A second, unmapped fault leaves the capture unchanged. i_fault_clr then clears valid, code and adr.
- Slave 0 acks exactly on BUSY cycle 255 -> ack delivered, no error. Master drops stb on BUSY cycle 5 -> back to IDLE, no ack, no error.
- Assert i_rb low during BUSY -> o_s_stb = 0 and o_m_ack = 0 immediately. After release, a new request completes normally.
